// File: rtl/frogger_win_controller.sv
// Level-flow controller for the frog game. Watches the row-status code coming
// from the last-register comparator, debounces a win, runs a timed celebration
// with a blink pattern, handshakes a playfield clear with the register bank and
// then advances the level. Frog moves (rising edges of code 01) are counted
// per level with saturation.
module frogger_win_controller #(
  parameter int LEVEL_WIDTH      = 4,
  parameter int MAX_LEVEL        = 9,
  parameter int CELEBRATE_CYCLES = 16,
  parameter int BLINK_DIV        = 4,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                   frogger_win_controller_CLOCK_50,
  input  logic                   frogger_win_controller_RESET_InLow,
  input  logic [1:0]             frogger_win_controller_win_InBUS,
  input  logic                   frogger_win_controller_clearAck_In,
  output logic                   frogger_win_controller_clearRegs_Out,
  output logic [LEVEL_WIDTH-1:0] frogger_win_controller_level_OutBUS,
  output logic [CNT_WIDTH-1:0]   frogger_win_controller_moves_OutBUS,
  output logic                   frogger_win_controller_celebrate_Out,
  output logic                   frogger_win_controller_blink_Out,
  output logic                   frogger_win_controller_done_Out
);

  typedef enum logic [2:0] {
    PLAY      = 3'd0,
    CONFIRM   = 3'd1,
    CELEBRATE = 3'd2,
    CLEAR     = 3'd3,
    ADVANCE   = 3'd4,
    DONE      = 3'd5
  } stateT;

  localparam logic [1:0] CODE_IDLE    = 2'b00;
  localparam logic [1:0] CODE_CHANGED = 2'b01;
  localparam logic [1:0] CODE_FULL    = 2'b11;

  localparam logic [CNT_WIDTH-1:0]   CEL_LAST   = CNT_WIDTH'(CELEBRATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]   BLINK_LAST = CNT_WIDTH'(BLINK_DIV - 1);
  localparam logic [CNT_WIDTH-1:0]   MOVES_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX  = LEVEL_WIDTH'(MAX_LEVEL);

  logic                   clk;
  logic                   rstN;
  logic [1:0]             codeNow;
  logic                   moveEdge;
  logic [LEVEL_WIDTH-1:0] levelNext;

  stateT                  stateReg;
  logic [1:0]             prevReg;
  logic [CNT_WIDTH-1:0]   movesReg;
  logic [CNT_WIDTH-1:0]   celCntReg;
  logic [CNT_WIDTH-1:0]   blinkCntReg;
  logic [LEVEL_WIDTH-1:0] levelReg;
  logic                   blinkReg;
  logic                   clearRegsReg;
  logic                   celebrateReg;
  logic                   doneReg;

  assign clk  = frogger_win_controller_CLOCK_50;
  assign rstN = frogger_win_controller_RESET_InLow;

  // Code 10 carries no meaning; fold it into idle so it can never look like a move or win.
  assign codeNow = (frogger_win_controller_win_InBUS == 2'b10) ? CODE_IDLE
                                                               : frogger_win_controller_win_InBUS;

  // A move is only the first cycle of a 01 run.
  assign moveEdge = (codeNow == CODE_CHANGED) && (prevReg != CODE_CHANGED);

  // Level after an advance; pinned at the final level so it can never wrap.
  assign levelNext = (levelReg >= LEVEL_MAX) ? LEVEL_MAX : levelReg + 1'b1;

  // Level-flow state machine; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      stateReg     <= PLAY;
      prevReg      <= CODE_IDLE;
      movesReg     <= '0;
      celCntReg    <= '0;
      blinkCntReg  <= '0;
      levelReg     <= '0;
      blinkReg     <= 1'b0;
      clearRegsReg <= 1'b0;
      celebrateReg <= 1'b0;
      doneReg      <= 1'b0;
    end else begin
      prevReg <= codeNow;
      case (stateReg)
        PLAY: begin
          if (codeNow == CODE_FULL) begin
            stateReg <= CONFIRM;
          end else if (moveEdge && (movesReg != MOVES_MAX)) begin
            movesReg <= movesReg + 1'b1;
          end
        end
        CONFIRM: begin
          if (codeNow == CODE_FULL) begin
            stateReg     <= CELEBRATE;
            celCntReg    <= '0;
            blinkCntReg  <= '0;
            blinkReg     <= 1'b0;
            celebrateReg <= 1'b1;
          end else begin
            stateReg <= PLAY;
          end
        end
        CELEBRATE: begin
          if (celCntReg == CEL_LAST) begin
            stateReg     <= CLEAR;
            celCntReg    <= '0;
            blinkCntReg  <= '0;
            blinkReg     <= 1'b0;
            celebrateReg <= 1'b0;
            clearRegsReg <= 1'b1;
          end else begin
            celCntReg <= celCntReg + 1'b1;
            if (blinkCntReg == BLINK_LAST) begin
              blinkCntReg <= '0;
              blinkReg    <= ~blinkReg;
            end else begin
              blinkCntReg <= blinkCntReg + 1'b1;
            end
          end
        end
        CLEAR: begin
          if (frogger_win_controller_clearAck_In) begin
            stateReg     <= ADVANCE;
            clearRegsReg <= 1'b0;
          end
        end
        ADVANCE: begin
          levelReg <= levelNext;
          movesReg <= '0;
          if (levelNext == LEVEL_MAX) begin
            stateReg <= DONE;
            doneReg  <= 1'b1;
          end else begin
            stateReg <= PLAY;
          end
        end
        DONE: begin
          stateReg <= DONE;
        end
        default: begin
          stateReg     <= PLAY;
          blinkReg     <= 1'b0;
          clearRegsReg <= 1'b0;
          celebrateReg <= 1'b0;
          doneReg      <= 1'b0;
        end
      endcase
    end
  end

  assign frogger_win_controller_clearRegs_Out = clearRegsReg;
  assign frogger_win_controller_level_OutBUS  = levelReg;
  assign frogger_win_controller_moves_OutBUS  = movesReg;
  assign frogger_win_controller_celebrate_Out = celebrateReg;
  assign frogger_win_controller_blink_Out     = blinkReg;
  assign frogger_win_controller_done_Out      = doneReg;

endmodule

// File: tb/tb_frogger_win_controller.sv
// Bench for frogger_win_controller with a short celebration (4 cycles), blink
// period 2 and a two-level game. Each scenario queues rows of
// {reset, win code, clearAck, expected outputs}; expected outputs go onto a
// scoreboard as the row is driven and are popped and compared one edge later.
module tb_frogger_win_controller;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [1:0] win = 2'b00;
  logic       ack = 1'b0;
  logic       clearRegs;
  logic [3:0] level;
  logic [7:0] moves;
  logic       celebrate;
  logic       blink;
  logic       done;

  int testsRun  = 0;
  int failCount = 0;

  typedef struct {
    logic        rstN;
    logic [1:0]  win;
    logic        ack;
    logic [15:0] exp;
  } rowT;

  rowT         rowQ[$];
  logic [15:0] expQ[$];

  frogger_win_controller #(
    .LEVEL_WIDTH     (4),
    .MAX_LEVEL       (2),
    .CELEBRATE_CYCLES(4),
    .BLINK_DIV       (2),
    .CNT_WIDTH       (8)
  ) dut (
    .frogger_win_controller_CLOCK_50     (clk),
    .frogger_win_controller_RESET_InLow  (rstN),
    .frogger_win_controller_win_InBUS    (win),
    .frogger_win_controller_clearAck_In  (ack),
    .frogger_win_controller_clearRegs_Out(clearRegs),
    .frogger_win_controller_level_OutBUS (level),
    .frogger_win_controller_moves_OutBUS (moves),
    .frogger_win_controller_celebrate_Out(celebrate),
    .frogger_win_controller_blink_Out    (blink),
    .frogger_win_controller_done_Out     (done)
  );

  always #5 clk = ~clk;

  // Output vector layout: {clearRegs, celebrate, blink, done, level[3:0], moves[7:0]}
  function automatic logic [15:0] mk(input logic cr, input logic ce, input logic bl,
                                     input logic dn, input int lv, input int mv);
    logic [3:0] l;
    logic [7:0] m;
    l = lv[3:0];
    m = mv[7:0];
    return {cr, ce, bl, dn, l, m};
  endfunction

  function automatic logic [15:0] observed();
    return {clearRegs, celebrate, blink, done, level, moves};
  endfunction

  task automatic row(input logic r, input logic [1:0] w, input logic a, input logic [15:0] e);
    rowT t;
    t.rstN = r;
    t.win  = w;
    t.ack  = a;
    t.exp  = e;
    rowQ.push_back(t);
  endtask

  // One complete win at level lv with moves==0: CONFIRM, 4 CELEBRATE cycles
  // (clearAck high there to show it is ignored), CLEAR acked on its first cycle.
  task automatic winRows(input int lv, input logic lastLevel);
    row(1'b1, 2'b11, 1'b0, mk(0, 0, 0, 0, lv, 0));
    row(1'b1, 2'b11, 1'b1, mk(0, 1, 0, 0, lv, 0));
    row(1'b1, 2'b11, 1'b1, mk(0, 1, 0, 0, lv, 0));
    row(1'b1, 2'b11, 1'b1, mk(0, 1, 1, 0, lv, 0));
    row(1'b1, 2'b11, 1'b1, mk(0, 1, 1, 0, lv, 0));
    row(1'b1, 2'b11, 1'b0, mk(1, 0, 0, 0, lv, 0));
    row(1'b1, 2'b00, 1'b1, mk(0, 0, 0, 0, lv, 0));
    row(1'b1, 2'b00, 1'b0, mk(0, 0, 0, lastLevel, lv + 1, 0));
  endtask

  task automatic test_reset();
    rowT t;
    logic [15:0] e, got;
    int i = 0;
    row(1'b0, 2'b11, 1'b1, mk(0, 0, 0, 0, 0, 0));
    row(1'b0, 2'b11, 1'b1, mk(0, 0, 0, 0, 0, 0));
    row(1'b1, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));
    row(1'b1, 2'b01, 1'b0, mk(0, 0, 0, 0, 0, 1));
    while (rowQ.size() > 0) begin
      t = rowQ.pop_front();
      rstN = t.rstN; win = t.win; ack = t.ack;
      expQ.push_back(t.exp);
      @(posedge clk); #1;
      got = observed();
      e = expQ.pop_front();
      $display("[TB] test_reset #%0d rst=%b win=%b ack=%b out=%h", i, t.rstN, t.win, t.ack, got);
      testsRun++;
      if (got !== e) begin
        failCount++;
        $display("FAIL test_reset #%0d: got %h expected %h", i, got, e);
      end
      i++;
    end
  endtask

  task automatic test_moves();
    rowT t;
    logic [15:0] e, got;
    logic [1:0] seq[7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01, 2'b10, 2'b01};
    int expMoves[7] = '{0, 1, 1, 1, 2, 2, 3};
    int m = 3;
    int i = 0;
    row(1'b0, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 7; k++) row(1'b1, seq[k], 1'b0, mk(0, 0, 0, 0, 0, expMoves[k]));
    // A held 01 is a single move.
    for (int k = 0; k < 10; k++) row(1'b1, 2'b01, 1'b0, mk(0, 0, 0, 0, 0, 3));
    // 300 separate moves drive the counter into saturation.
    for (int k = 0; k < 300; k++) begin
      row(1'b1, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, m));
      m = (m < 255) ? m + 1 : 255;
      row(1'b1, 2'b01, 1'b0, mk(0, 0, 0, 0, 0, m));
    end
    row(1'b1, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 255));
    while (rowQ.size() > 0) begin
      t = rowQ.pop_front();
      rstN = t.rstN; win = t.win; ack = t.ack;
      expQ.push_back(t.exp);
      @(posedge clk); #1;
      got = observed();
      e = expQ.pop_front();
      $display("[TB] test_moves #%0d rst=%b win=%b ack=%b out=%h", i, t.rstN, t.win, t.ack, got);
      testsRun++;
      if (got !== e) begin
        failCount++;
        $display("FAIL test_moves #%0d: got %h expected %h", i, got, e);
      end
      i++;
    end
  endtask

  task automatic test_confirm_bounce();
    rowT t;
    logic [15:0] e, got;
    int i = 0;
    row(1'b0, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));
    row(1'b1, 2'b11, 1'b0, mk(0, 0, 0, 0, 0, 0));  // PLAY -> CONFIRM
    row(1'b1, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));  // bounce back to PLAY
    row(1'b1, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));
    row(1'b1, 2'b11, 1'b0, mk(0, 0, 0, 0, 0, 0));  // CONFIRM again
    row(1'b1, 2'b01, 1'b0, mk(0, 0, 0, 0, 0, 0));  // 01 edge in CONFIRM not counted
    row(1'b1, 2'b01, 1'b0, mk(0, 0, 0, 0, 0, 0));  // still the same 01 run
    row(1'b1, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));
    row(1'b1, 2'b01, 1'b0, mk(0, 0, 0, 0, 0, 1));
    row(1'b1, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 1));
    while (rowQ.size() > 0) begin
      t = rowQ.pop_front();
      rstN = t.rstN; win = t.win; ack = t.ack;
      expQ.push_back(t.exp);
      @(posedge clk); #1;
      got = observed();
      e = expQ.pop_front();
      $display("[TB] test_confirm_bounce #%0d rst=%b win=%b ack=%b out=%h", i, t.rstN, t.win, t.ack, got);
      testsRun++;
      if (got !== e) begin
        failCount++;
        $display("FAIL test_confirm_bounce #%0d: got %h expected %h", i, got, e);
      end
      i++;
    end
  endtask

  task automatic test_celebrate_clear();
    rowT t;
    logic [15:0] e, got;
    int i = 0;
    row(1'b0, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));
    row(1'b1, 2'b01, 1'b0, mk(0, 0, 0, 0, 0, 1));  // one move so the clear is visible
    row(1'b1, 2'b11, 1'b0, mk(0, 0, 0, 0, 0, 1));  // CONFIRM
    row(1'b1, 2'b11, 1'b0, mk(0, 1, 0, 0, 0, 1));  // CELEBRATE cycle 1
    row(1'b1, 2'b11, 1'b0, mk(0, 1, 0, 0, 0, 1));
    row(1'b1, 2'b11, 1'b0, mk(0, 1, 1, 0, 0, 1));
    row(1'b1, 2'b11, 1'b0, mk(0, 1, 1, 0, 0, 1));
    row(1'b1, 2'b11, 1'b0, mk(1, 0, 0, 0, 0, 1));  // CLEAR cycle 1
    row(1'b1, 2'b00, 1'b0, mk(1, 0, 0, 0, 0, 1));
    row(1'b1, 2'b00, 1'b0, mk(1, 0, 0, 0, 0, 1));
    row(1'b1, 2'b00, 1'b1, mk(0, 0, 0, 0, 0, 1));  // ack -> ADVANCE
    row(1'b1, 2'b00, 1'b0, mk(0, 0, 0, 0, 1, 0));  // PLAY, level 1
    row(1'b1, 2'b00, 1'b1, mk(0, 0, 0, 0, 1, 0));  // ack outside CLEAR ignored
    while (rowQ.size() > 0) begin
      t = rowQ.pop_front();
      rstN = t.rstN; win = t.win; ack = t.ack;
      expQ.push_back(t.exp);
      @(posedge clk); #1;
      got = observed();
      e = expQ.pop_front();
      $display("[TB] test_celebrate_clear #%0d rst=%b win=%b ack=%b out=%h", i, t.rstN, t.win, t.ack, got);
      testsRun++;
      if (got !== e) begin
        failCount++;
        $display("FAIL test_celebrate_clear #%0d: got %h expected %h", i, got, e);
      end
      i++;
    end
  endtask

  task automatic test_levels_done();
    rowT t;
    logic [15:0] e, got;
    logic [1:0] junk[6] = '{2'b11, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11};
    int i = 0;
    row(1'b0, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));
    winRows(0, 1'b0);
    winRows(1, 1'b1);
    for (int k = 0; k < 6; k++) row(1'b1, junk[k], k[0], mk(0, 0, 0, 1, 2, 0));
    row(1'b0, 2'b11, 1'b1, mk(0, 0, 0, 0, 0, 0));
    row(1'b1, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));
    while (rowQ.size() > 0) begin
      t = rowQ.pop_front();
      rstN = t.rstN; win = t.win; ack = t.ack;
      expQ.push_back(t.exp);
      @(posedge clk); #1;
      got = observed();
      e = expQ.pop_front();
      $display("[TB] test_levels_done #%0d rst=%b win=%b ack=%b out=%h", i, t.rstN, t.win, t.ack, got);
      testsRun++;
      if (got !== e) begin
        failCount++;
        $display("FAIL test_levels_done #%0d: got %h expected %h", i, got, e);
      end
      i++;
    end
  endtask

  task automatic test_reset_mid_clear();
    rowT t;
    logic [15:0] e, got;
    int i = 0;
    row(1'b0, 2'b00, 1'b0, mk(0, 0, 0, 0, 0, 0));
    winRows(0, 1'b0);
    row(1'b1, 2'b11, 1'b0, mk(0, 0, 0, 0, 1, 0));
    row(1'b1, 2'b11, 1'b0, mk(0, 1, 0, 0, 1, 0));
    row(1'b1, 2'b11, 1'b0, mk(0, 1, 0, 0, 1, 0));
    row(1'b1, 2'b11, 1'b0, mk(0, 1, 1, 0, 1, 0));
    row(1'b1, 2'b11, 1'b0, mk(0, 1, 1, 0, 1, 0));
    row(1'b1, 2'b11, 1'b0, mk(1, 0, 0, 0, 1, 0));  // CLEAR
    row(1'b1, 2'b00, 1'b0, mk(1, 0, 0, 0, 1, 0));
    row(1'b0, 2'b00, 1'b1, mk(0, 0, 0, 0, 0, 0));  // reset wins over ack
    row(1'b1, 2'b11, 1'b0, mk(0, 0, 0, 0, 0, 0));  // PLAY -> CONFIRM
    row(1'b1, 2'b11, 1'b0, mk(0, 1, 0, 0, 0, 0));  // normal win latency from PLAY
    while (rowQ.size() > 0) begin
      t = rowQ.pop_front();
      rstN = t.rstN; win = t.win; ack = t.ack;
      expQ.push_back(t.exp);
      @(posedge clk); #1;
      got = observed();
      e = expQ.pop_front();
      $display("[TB] test_reset_mid_clear #%0d rst=%b win=%b ack=%b out=%h", i, t.rstN, t.win, t.ack, got);
      testsRun++;
      if (got !== e) begin
        failCount++;
        $display("FAIL test_reset_mid_clear #%0d: got %h expected %h", i, got, e);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_moves();
    test_confirm_bounce();
    test_celebrate_clear();
    test_levels_done();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
